// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider and baud tick source.
// Divides i_clk by N in [2, 2^P_DIV_W-1] and produces a registered divided
// clock plus one-cycle rise/fall strobes. Meant for use as a clock enable.
// Optional macro CLK_DIV_ODD_5050_EN: for odd N, a negedge flop stretches the
// high phase by half an i_clk period, so the duty cycle is exactly 50%.
//
// state  | meaning
// S_IDLE | stopped, counter held at 0, divisor writes apply directly
// S_RUN  | counting, divisor writes held pending until the next wrap
module clk_div_prog #(
  parameter int P_DIV_W   = 16,
  parameter int P_DIV_RST = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [P_DIV_W-1:0] i_div,
  input  logic               i_div_vld,
  output logic               o_div_rdy,
  output logic               o_clk_div,
  output logic               o_rise_tick,
  output logic               o_fall_tick,
  output logic               o_busy,
  output logic [P_DIV_W-1:0] o_div_cur
);

  localparam logic [P_DIV_W-1:0] DIV_MIN = P_DIV_W'(2);
  localparam logic [P_DIV_W-1:0] DIV_RST = P_DIV_W'(P_DIV_RST);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [P_DIV_W-1:0] cnt, cnt_nxt;
  logic [P_DIV_W-1:0] div_act, div_nxt;
  logic [P_DIV_W-1:0] div_pend, pend_div_nxt;
  logic               pend_vld, pend_nxt;
  logic               clk_pos, clk_pos_nxt;
  logic               rise_nxt, fall_nxt;
  logic               run_nxt;
  logic               hs;
  logic               wrap;
  logic [P_DIV_W-1:0] div_clamp;
  logic [P_DIV_W:0]   h_nxt;
  logic [P_DIV_W:0]   hi_thresh;

  assign hs        = i_div_vld & o_div_rdy;
  assign div_clamp = (i_div < DIV_MIN) ? DIV_MIN : i_div;
  assign wrap      = (cnt == (div_act - P_DIV_W'(1)));

  // Next-state, counter and divisor selection for the coming cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    div_nxt      = div_act;
    pend_nxt     = pend_vld;
    pend_div_nxt = div_pend;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (hs) div_nxt = div_clamp;
        if (i_en) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (wrap) begin
          cnt_nxt = '0;
          if (pend_vld) begin
            div_nxt  = div_pend;
            pend_nxt = 1'b0;
          end
          if (!i_en) begin
            // Stopping: a write landing on this edge goes straight to active.
            state_nxt = S_IDLE;
            if (hs) div_nxt = div_clamp;
          end else if (hs) begin
            // Write on the wrap edge waits for the following wrap.
            pend_nxt     = 1'b1;
            pend_div_nxt = div_clamp;
          end
        end else begin
          cnt_nxt = cnt + P_DIV_W'(1);
          if (hs) begin
            pend_nxt     = 1'b1;
            pend_div_nxt = div_clamp;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next counter value and the divisor for that cycle.
  always_comb begin
    run_nxt = (state_nxt == S_RUN);
    h_nxt   = ({1'b0, div_nxt} + {{P_DIV_W{1'b0}}, 1'b1}) >> 1;
`ifdef CLK_DIV_ODD_5050_EN
    // Odd N: posedge version is high floor(N/2) cycles; the negedge copy adds
    // the missing half cycle.
    hi_thresh = h_nxt - {{P_DIV_W{1'b0}}, div_nxt[0]};
`else
    hi_thresh = h_nxt;
`endif
    clk_pos_nxt = run_nxt && ({1'b0, cnt_nxt} < hi_thresh);
    rise_nxt    = run_nxt && (cnt_nxt == '0);
    fall_nxt    = run_nxt && ({1'b0, cnt_nxt} == h_nxt);
  end

  // State, counter, divisor and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      div_act     <= DIV_RST;
      div_pend    <= DIV_RST;
      pend_vld    <= 1'b0;
      clk_pos     <= 1'b0;
      o_rise_tick <= 1'b0;
      o_fall_tick <= 1'b0;
      o_busy      <= 1'b0;
      o_div_rdy   <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      div_act     <= div_nxt;
      div_pend    <= pend_div_nxt;
      pend_vld    <= pend_nxt;
      clk_pos     <= clk_pos_nxt;
      o_rise_tick <= rise_nxt;
      o_fall_tick <= fall_nxt;
      o_busy      <= run_nxt;
      o_div_rdy   <= ~pend_nxt;
    end
  end

  assign o_div_cur = div_act;

`ifdef CLK_DIV_ODD_5050_EN
  logic clk_neg;

  // Half-cycle delayed copy of the high phase, only for odd divisors.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) clk_neg <= 1'b0;
    else       clk_neg <= clk_pos & div_act[0];
  end

  assign o_clk_div = clk_pos | clk_neg;
`else
  assign o_clk_div = clk_pos;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios with literal
// expectations, then randomized enable/divisor/reset traffic against a
// period-position model.
module tb_clk_div_prog;

  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_en;
  logic [W-1:0] i_div;
  logic         i_div_vld;
  logic         o_div_rdy, o_clk_div, o_rise_tick, o_fall_tick, o_busy;
  logic [W-1:0] o_div_cur;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.P_DIV_W(W), .P_DIV_RST(2)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_div       (i_div),
    .i_div_vld   (i_div_vld),
    .o_div_rdy   (o_div_rdy),
    .o_clk_div   (o_clk_div),
    .o_rise_tick (o_rise_tick),
    .o_fall_tick (o_fall_tick),
    .o_busy      (o_busy),
    .o_div_cur   (o_div_cur)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: running flag, position within the current period, active and
  // pending divisor.
  bit m_run;
  int m_pos;
  int m_n;
  bit m_pend;
  int m_pn;

  function automatic int clamp(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  initial begin : model_and_compare
    bit en, vld, hs;
    int d, h;
    m_run = 0; m_pos = 0; m_n = 2; m_pend = 0; m_pn = 2;
    forever begin
      @(posedge i_clk);
      en = i_en; vld = i_div_vld; d = int'(i_div);
      if (i_rst) begin
        m_run = 0; m_pos = 0; m_n = 2; m_pend = 0;
      end else begin
        hs = vld && !m_pend;
        if (!m_run) begin
          if (hs) m_n = clamp(d);
          if (en) begin m_run = 1; m_pos = 0; end
        end else if (m_pos == m_n - 1) begin
          m_pos = 0;
          if (m_pend) begin m_n = m_pn; m_pend = 0; end
          if (!en) begin
            m_run = 0;
            if (hs) m_n = clamp(d);
          end else if (hs) begin
            m_pend = 1; m_pn = clamp(d);
          end
        end else begin
          m_pos++;
          if (hs) begin m_pend = 1; m_pn = clamp(d); end
        end
      end
      #1;
      if (!i_rst) begin
        h = (m_n + 1) / 2;
        chk("m_clk",  o_clk_div,   (m_run && m_pos < h)  ? 1 : 0);
        chk("m_rise", o_rise_tick, (m_run && m_pos == 0) ? 1 : 0);
        chk("m_fall", o_fall_tick, (m_run && m_pos == h) ? 1 : 0);
        chk("m_busy", o_busy,      m_run ? 1 : 0);
        chk("m_rdy",  o_div_rdy,   m_pend ? 0 : 1);
        chk("m_cur",  o_div_cur,   m_n);
      end
    end
  end

  task automatic load_div(input int d);
    @(negedge i_clk);
    i_div = W'(d); i_div_vld = 1'b1;
    @(negedge i_clk);
    i_div_vld = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin : stim
    int highs, rises, falls;
    i_rst = 1'b1; i_en = 1'b0; i_div = '0; i_div_vld = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_clk",  o_clk_div, 0);
    chk("rst_rise", o_rise_tick, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rdy",  o_div_rdy, 1);
    chk("rst_cur",  o_div_cur, 2);

    // Default N=2: 1,0,1,0 starting one cycle after enable is sampled.
    @(negedge i_clk); i_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #2;
      chk("n2_clk",  o_clk_div,   (i % 2 == 0) ? 1 : 0);
      chk("n2_rise", o_rise_tick, (i % 2 == 0) ? 1 : 0);
    end
    @(negedge i_clk); i_en = 1'b0;
    idle_cycles(4);
    chk("n2_stop_busy", o_busy, 0);

    // N=5 loaded in IDLE: 3 high, 2 low per period.
    load_div(5);
    chk("n5_cur", o_div_cur, 5);
    chk("n5_rdy", o_div_rdy, 1);
    @(negedge i_clk); i_en = 1'b1;
    highs = 0; rises = 0; falls = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #2;
      highs += int'(o_clk_div); rises += int'(o_rise_tick); falls += int'(o_fall_tick);
      if (i == 3) chk("n5_fall_at3", o_fall_tick, 1);
    end
    chk("n5_highs", highs, 6);
    chk("n5_rises", rises, 2);
    chk("n5_falls", falls, 2);
    @(negedge i_clk); i_en = 1'b0;
    idle_cycles(8);

    // Clamp of 0 and 1.
    load_div(0);
    chk("clamp0", o_div_cur, 2);
    load_div(1);
    chk("clamp1", o_div_cur, 2);

    // N=4 running, load 6 mid-period.
    load_div(4);
    @(negedge i_clk); i_en = 1'b1;
    idle_cycles(1);
    i_div = W'(6); i_div_vld = 1'b1;
    @(negedge i_clk); i_div_vld = 1'b0;
    chk("chg_rdy_low", o_div_rdy, 0);
    chk("chg_cur_old", o_div_cur, 4);
    idle_cycles(3);
    chk("chg_cur_new", o_div_cur, 6);
    chk("chg_rdy_back", o_div_rdy, 1);
    idle_cycles(12);
    @(negedge i_clk); i_en = 1'b0;
    idle_cycles(8);

    // N=8: drop enable at count 2, period completes, no extra rise.
    load_div(8);
    @(negedge i_clk); i_en = 1'b1;
    idle_cycles(2);
    i_en = 1'b0;
    idle_cycles(5);
    chk("stop_busy_in_period", o_busy, 1);
    idle_cycles(2);
    chk("stop_busy", o_busy, 0);
    chk("stop_clk", o_clk_div, 0);
    chk("stop_rise", o_rise_tick, 0);
    // Reassert at count 5: no gap.
    @(negedge i_clk); i_en = 1'b1;
    idle_cycles(3);
    i_en = 1'b0;
    idle_cycles(2);
    i_en = 1'b1;
    idle_cycles(4);
    chk("resume_busy", o_busy, 1);
    @(negedge i_clk); i_en = 1'b0;
    idle_cycles(10);

    // N=7: pending divisor, then reset at count 3.
    load_div(7);
    @(negedge i_clk); i_en = 1'b1;
    idle_cycles(1);
    i_div = W'(9); i_div_vld = 1'b1;
    @(negedge i_clk); i_div_vld = 1'b0;
    idle_cycles(1);
    i_rst = 1'b1;
    #1;
    chk("mrst_clk",  o_clk_div, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_rdy",  o_div_rdy, 1);
    chk("mrst_cur",  o_div_cur, 2);
    chk("mrst_fall", o_fall_tick, 0);
    i_en = 1'b0;
    @(negedge i_clk); i_rst = 1'b0;
    idle_cycles(2);
    chk("mrst_cur_after", o_div_cur, 2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge i_clk);
      if ($urandom_range(0, 99) < 8) i_en = ~i_en;
      i_div_vld = ($urandom_range(0, 99) < 15);
      i_div     = W'($urandom_range(0, 9));
      i_rst     = ($urandom_range(0, 999) < 3);
    end
    @(negedge i_clk);
    i_rst = 1'b0; i_div_vld = 1'b0; i_en = 1'b0;
    idle_cycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock divider and baud tick source for the UART datapath.
- Divides i_clk by any integer N in [2, 2^P_DIV_W-1]; the divisor is loaded through a valid/ready handshake.
- Produces a registered divided clock, one-cycle rise/fall tick strobes, and starts/stops gracefully on period boundaries.
- Feeds the TX/RX bit-timing logic as a clock-enable source; o_clk_div is not used as a global clock.

Parameters:
- P_DIV_W, 16, width of the divisor and the internal counter.
- P_DIV_RST, 2, active divisor after reset; must be >= 2.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, asynchronous, active-high
- i_en  input  1  run request; level-sensitive
- i_div  input  P_DIV_W  new divisor N
- i_div_vld  input  1  divisor valid
- o_div_rdy  output  1  divisor ready; transfer occurs when i_div_vld and o_div_rdy are both high on a rising edge
- o_clk_div  output  1  divided clock, registered
- o_rise_tick  output  1  one-cycle pulse aligned with the o_clk_div 0->1 transition
- o_fall_tick  output  1  one-cycle pulse aligned with the o_clk_div 1->0 transition
- o_busy  output  1  high while in RUN
- o_div_cur  output  P_DIV_W  divisor currently in effect

Behaviour:
- Reset (i_i_rst high, asynchronous) sets the following values:
  - state IDLE, counter 0, active divisor P_DIV_RST, no pending divisor.
  - o_clk_div=0, o_rise_tick=0, o_fall_tick=0, o_busy=0, o_div_rdy=1, o_div_cur=P_DIV_RST.
- Divisor clamp: an accepted i_div of 0 or 1 is stored as 2. All comparisons are unsigned in P_DIV_W bits.
- Phase lengths: H = ceil(N/2) cycles high, L = floor(N/2) cycles low; H is computed as (N+1)>>1 in P_DIV_W+1 bits.
- State IDLE:
  - Counter is held at 0 and o_clk_div=0.
  - A handshake writes the active divisor directly; o_div_cur updates the next cycle and o_div_rdy stays 1.
  - i_en=1 sampled -> next cycle enters RUN with counter=0, o_clk_div=1, o_rise_tick=1, o_busy=1. Latency is one cycle.
- State RUN:
  - Counter increments every cycle and wraps from N-1 to 0.
  - Registered output: o_clk_div = (counter_next < H).
  - o_rise_tick=1 when counter_next==0; o_fall_tick=1 when counter_next==H.
  - Period length is exactly N cycles.
- Divisor change in RUN:
  - A handshake stores the value in a pending register, and o_div_rdy drops to 0 the next cycle.
  - At the next wrap (counter==N-1), the pending value becomes active, o_div_cur updates, and o_div_rdy returns to 1.
  - If a handshake occurs in the same cycle as a wrap, the value is applied at the following wrap, not at this one.
  - A new period never uses a mix of old and new divisors.
- Stop:
  - i_en=0 does not truncate the current period.
  - At the wrap with i_en=0 the block returns to IDLE: o_clk_div=0, o_busy=0, no rise tick. A pending divisor is applied at that same transition.
  - If i_en returns to 1 before the wrap, running continues seamlessly.
- Reset mid-period: every output goes immediately to its reset value and any pending divisor is discarded.
- o_rise_tick and o_fall_tick are never high in the same cycle, since H >= 1 and H < N for N >= 2.

Optional Feature:
- Macro: CLK_DIV_ODD_5050_EN.
- Defined:
  - For odd N, a negedge-i_clk flop delays the falling phase by half an i_clk period.
  - o_clk_div is the OR of the posedge and negedge versions, giving an exact 50% duty cycle (N/2 high).
  - o_fall_tick stays posedge-aligned at counter_next==H.
  - Even N behaviour is unchanged.
- Undefined: no negedge logic; odd N produces duty H/N as described above.

Test Plan:
- Reset, then i_en=1 with default N=2 -> o_clk_div toggles 1,0,1,0 starting one cycle after i_en is sampled; a rise tick occurs every 2 cycles; o_div_cur=2.
- Load i_div=5 in IDLE, then run -> period 5 cycles: high 3, low 2; rise ticks 5 cycles apart; fall tick at count 3. With CLK_DIV_ODD_5050_EN defined, high time is 2.5 i_clk periods.
- While running N=4, load i_div=6 mid-period -> o_div_rdy=0 until the wrap; current period completes as 4 cycles, then periods are 6 cycles; o_div_cur changes 4->6 at the wrap.
- Load i_div=0 and i_div=1 -> o_div_cur=2 in both cases; output period is 2.
- With N=8, deassert i_en at count 2 -> the period finishes all 8 cycles; then o_busy=0 and o_clk_div=0 with no extra rise tick. Reassert i_en at count 5 instead -> no gap in the output.
- Assert i_rst at count 3 of N=7 -> all outputs go to reset values immediately and the pending divisor is dropped; o_div_cur=P_DIV_RST after release.
